// File: rtl/count_disp_pkg.sv
// Shared types and constants for the BCD conversion / seven-segment display block.
package count_disp_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int NUM_DIGITS = 3;

  // Active-high patterns, {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift
  function automatic logic [11:0] add3(input logic [11:0] s);
    logic [11:0] r;
    for (int i = 0; i < NUM_DIGITS; i++)
      r[4*i +: 4] = (s[4*i +: 4] >= 4'd5) ? s[4*i +: 4] + 4'd3 : s[4*i +: 4];
    return r;
  endfunction

endpackage

// File: rtl/count_bcd_display_seg7_decode.sv
// Single-digit seven-segment decoder, active-high; blank forces all segments off.
module seg7_decode
  import count_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    pattern = SEG_0;
        4'd1:    pattern = SEG_1;
        4'd2:    pattern = SEG_2;
        4'd3:    pattern = SEG_3;
        4'd4:    pattern = SEG_4;
        4'd5:    pattern = SEG_5;
        4'd6:    pattern = SEG_6;
        4'd7:    pattern = SEG_7;
        4'd8:    pattern = SEG_8;
        4'd9:    pattern = SEG_9;
        default: pattern = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/count_bcd_display.sv
// Samples the counter value, converts it to BCD serially, and drives a
// multiplexed 3-digit seven-segment display with leading-zero blanking.
module count_bcd_display
  import count_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  count,
  input  logic        sample,
  output logic        busy,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t      state;
  logic [7:0]  bin;
  logic [11:0] scratch;
  logic [11:0] adj;
  logic [2:0]  iter;

  assign adj  = add3(scratch);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      bin       <= '0;
      scratch   <= '0;
      iter      <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: if (sample) begin
          bin     <= count;
          scratch <= '0;
          iter    <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          {scratch, bin} <= {adj[10:0], bin, 1'b0};
          iter           <= iter + 3'd1;
          if (iter == 3'd7) state <= DONE;
        end
        DONE: begin
          bcd       <= scratch;
          bcd_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Refresh phase runs freely; conversions never disturb it
  logic [RW-1:0] rcnt;
  logic [1:0]    dsel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rcnt <= '0;
      dsel <= '0;
    end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      dsel <= (dsel == 2'd2) ? 2'd0 : dsel + 2'd1;
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end

  logic [NUM_DIGITS-1:0]      blank;
  logic [NUM_DIGITS-1:0][6:0] pats;

  always_comb begin
    blank    = '0;
    blank[2] = (bcd[11:8] == 4'd0);
    blank[1] = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .digit   (bcd[4*g +: 4]),
      .blank   (blank[g]),
      .pattern (pats[g])
    );
  end

  logic [6:0] seg_hi;
  logic [2:0] an_hi;

  always_comb begin
    case (dsel)
      2'd1:    begin seg_hi = pats[1]; an_hi = 3'b010; end
      2'd2:    begin seg_hi = pats[2]; an_hi = 3'b100; end
      default: begin seg_hi = pats[0]; an_hi = 3'b001; end
    endcase
  end

  assign seg = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
  assign an  = SEG_ACTIVE_LOW ? ~an_hi  : an_hi;

endmodule

// File: doc/count_bcd_display.md
# count_bcd_display

Downstream consumer of the 8-bit up/down load counter. It samples the counter's binary `count` on request and converts it to three BCD digits with a serial shift-add-3 (double-dabble) engine. It holds the result and drives a time-multiplexed 3-digit seven-segment display with leading-zero blanking.

## Interface

Parameters:
- `REFRESH_DIV`, default 1000: clk cycles each digit stays enabled. Must be ≥ 2.
- `SEG_ACTIVE_LOW`, default 1: when 1, `seg` and `an` are inverted (active-low drive).

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `count`  in  8  binary value from the counter.
- `sample`  in  1  conversion request. Accepted only in IDLE.
- `busy`  out  1  high while a conversion is in progress (SHIFT or DONE).
- `bcd`  out  12  held result, `{hundreds, tens, units}`, 4 bits per digit.
- `bcd_valid`  out  1  one-cycle pulse when `bcd` updates.
- `seg`  out  7  segment bits `{a,b,c,d,e,f,g}`, with `seg[6]` = a.
- `an`  out  3  digit enable, one-hot. `an[0]` = units, `an[2]` = hundreds.

## Operation

Conversion FSM has three states: IDLE, SHIFT, DONE.
- **IDLE**: `busy` = 0. When `sample` = 1 at an edge, `count` is captured into the binary shift register, the BCD scratch register is cleared, the iteration counter is set to 0, and the FSM goes to SHIFT.
- **SHIFT**: each cycle performs one iteration.
  - First, add 3 to every scratch nibble that is ≥ 5.
  - Then shift `{scratch, binary}` left by 1.
  - After the 8th iteration the FSM goes to DONE.
- **DONE**: for one cycle, the scratch register is copied to `bcd`, `bcd_valid` is asserted, and the FSM returns to IDLE.
- `sample` is ignored in SHIFT and DONE. Requests are not queued.
- Changes on `count` after capture do not affect the conversion in flight.
- Width rules:
  - Scratch register is 12 bits. The hundreds nibble never exceeds 2.
  - Maximum result is `12'h255`. No overflow is possible.

Display:
- A refresh counter runs 0..`REFRESH_DIV`-1 and wraps.
- On each wrap the digit select advances 0 → 1 → 2 → 0.
- `an` is one-hot on the selected digit. `seg` is the decoded pattern of that digit of `bcd` (the held register, not the scratch register).
- Active-high patterns:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - blank = 0000000
- Leading-zero blanking:
  - Hundreds is blank when it is 0.
  - Tens is blank when hundreds = 0 and tens = 0.
  - Units is never blanked.
- With `SEG_ACTIVE_LOW` = 1, both `seg` and `an` are bitwise inverted at the output.

## Timing

- Reset values:
  - FSM = IDLE, `busy` = 0, `bcd_valid` = 0, `bcd` = `12'h000`.
  - Refresh counter = 0, digit select = 0.
  - Outputs show units enabled with the "0" pattern. With default polarity: `an` = 3'b110, `seg` = 7'b0000001.
- Latency: `sample` accepted at edge E0.
  - `busy` is high after E0 through E9.
  - SHIFT iterations occur at edges E1..E8.
  - `bcd` and `bcd_valid` are updated at E9, and `busy` falls at E9.
  - The earliest next accepted `sample` is at E10.
- Throughput: one conversion per 10 cycles maximum.
- Reset mid-conversion: the FSM returns to IDLE, the conversion is aborted, `bcd_valid` is not asserted, and `bcd` is forced to 0.
- Display updates from a new `bcd` on the cycle after E9. The refresh phase is not disturbed by conversions.
- Digit period is exactly `REFRESH_DIV` cycles. The full frame is 3 × `REFRESH_DIV` cycles.

## Structure

- Package `count_disp_pkg`:
  - state typedef (IDLE/SHIFT/DONE)
  - `NUM_DIGITS` = 3
  - the ten segment pattern constants
  - `SEG_BLANK`
- Sub-module `seg7_decode`: combinational 4-bit digit plus blank flag → 7-bit active-high pattern. Polarity is applied in the top module.
- Top module contains the conversion FSM and datapath, the refresh counter and digit select, and the blanking logic.

## Test plan

- **Reset:** hold `rst` = 0 for 3 cycles, then release → `busy` = 0, `bcd` = `12'h000`, `an` = 3'b110, `seg` = 7'b0000001.
- **Full-scale conversion:** `count` = 8'd255, pulse `sample` → `bcd_valid` exactly 9 cycles later, `bcd` = `12'h255`, `busy` high for exactly 9 cycles.
- **Blanking:**
  - `count` = 8'd7 → `bcd` = `12'h007`; hundreds and tens blank.
  - `count` = 8'd100 → `bcd` = `12'h100`; tens shows "0" (not blanked).
- **Sample while busy:** convert 8'd157, re-pulse `sample` with `count` = 8'd3 at cycle +4 → single `bcd_valid`, `bcd` = `12'h157`.
- **Reset at cycle +5 of a conversion:** no `bcd_valid` pulse; `bcd` = 0 and `busy` = 0 after release.
- **Refresh with `REFRESH_DIV` = 4, `bcd` = `12'h213`:** `an` rotates units → tens → hundreds every 4 cycles; `seg` shows 3, 1, 2 respectively.
